// File: rtl/display_pkg.sv
// Segment constants shared by the clock-page display stages.
// Segment bytes are {a,b,c,d,e,f,g,dp}, active-high.
package display_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0     = 8'hFC;
    localparam seg_t SEG_1     = 8'h60;
    localparam seg_t SEG_2     = 8'hDA;
    localparam seg_t SEG_3     = 8'hF2;
    localparam seg_t SEG_4     = 8'h66;
    localparam seg_t SEG_5     = 8'hB6;
    localparam seg_t SEG_6     = 8'hBE;
    localparam seg_t SEG_7     = 8'hE0;
    localparam seg_t SEG_8     = 8'hFE;
    localparam seg_t SEG_9     = 8'hF6;
    localparam seg_t SEG_DASH  = 8'h02;
    localparam seg_t SEG_BLANK = 8'h00;

    localparam logic [3:0] NIB_SEP = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder; separator shows a dash, A..E blank.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            NIB_SEP: seg_o = SEG_DASH;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-tube multiplexed 7-segment driver with per-frame input capture and digit blinking.
module seg_scan_display
    import display_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] time_data,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  digit1,
    output logic [7:0]  digit2,
    output logic [7:0]  tube_sel
);

    localparam int unsigned ScanW  = $clog2(SCAN_DIV);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV);

    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_on_q, blink_on_d;
    logic              first_q;
    logic [31:0]       shadow_data_q, shadow_data_d;
    logic [7:0]        shadow_mask_q, shadow_mask_d;
    logic [7:0]        digit1_q, digit1_d;
    logic [7:0]        digit2_q, digit2_d;
    logic [7:0]        tube_sel_q, tube_sel_d;

    logic        scan_tc;
    logic        blink_tc;
    logic        frame_wrap;
    logic [31:0] cur_data;
    logic [7:0]  cur_mask;
    logic [3:0]  cur_nib;
    seg_t        dec_seg;
    seg_t        vis_seg;

    assign scan_tc    = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
    assign blink_tc   = (blink_cnt_q == BlinkW'(BLINK_DIV - 1));
    assign frame_wrap = scan_tc && (idx_q == 3'd0);

    // The first cycle after reset shows the freshly sampled inputs, not the cleared shadow.
    assign cur_data = first_q ? time_data : shadow_data_q;
    assign cur_mask = first_q ? blink_mask : shadow_mask_q;
    assign cur_nib  = cur_data[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        scan_cnt_d    = scan_tc ? '0 : scan_cnt_q + ScanW'(1);
        idx_d         = scan_tc ? idx_q - 3'd1 : idx_q;
        blink_cnt_d   = blink_tc ? '0 : blink_cnt_q + BlinkW'(1);
        blink_on_d    = blink_tc ? ~blink_on_q : blink_on_q;
        shadow_data_d = shadow_data_q;
        shadow_mask_d = shadow_mask_q;
        if (first_q || frame_wrap) begin
            shadow_data_d = time_data;
            shadow_mask_d = blink_mask;
        end

        vis_seg = (cur_mask[idx_q] && !blink_on_q) ? SEG_BLANK : dec_seg;

        tube_sel_d = 8'h01 << idx_q;
        digit1_d   = SEG_BLANK;
        digit2_d   = SEG_BLANK;
        if (idx_q[2]) begin
            digit1_d = vis_seg;
        end else begin
            digit2_d = vis_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            idx_q         <= 3'd7;
            blink_cnt_q   <= '0;
            blink_on_q    <= 1'b1;
            first_q       <= 1'b1;
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
            digit1_q      <= '0;
            digit2_q      <= '0;
            tube_sel_q    <= '0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_on_q    <= blink_on_d;
            first_q       <= 1'b0;
            shadow_data_q <= shadow_data_d;
            shadow_mask_q <= shadow_mask_d;
            digit1_q      <= digit1_d;
            digit2_q      <= digit2_d;
            tube_sel_q    <= tube_sel_d;
        end
    end

    assign digit1   = digit1_q;
    assign digit2   = digit2_q;
    assign tube_sel = tube_sel_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: directed and random steps checked against a cycle-count model.
module tb_seg_scan_display;

    localparam int S = 4;
    localparam int B = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] time_data = '0;
    logic [7:0]  blink_mask = '0;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  tube_sel;

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset release plus the frame-latched inputs.
    int          k = 0;
    logic [31:0] sh_data = '0;
    logic [7:0]  sh_mask = '0;

    seg_scan_display #(
        .SCAN_DIV  (S),
        .BLINK_DIV (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .time_data  (time_data),
        .blink_mask (blink_mask),
        .digit1     (digit1),
        .digit2     (digit2),
        .tube_sel   (tube_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_seg(input logic [3:0] n);
        case (n)
            4'd0: return 8'hFC;
            4'd1: return 8'h60;
            4'd2: return 8'hDA;
            4'd3: return 8'hF2;
            4'd4: return 8'h66;
            4'd5: return 8'hB6;
            4'd6: return 8'hBE;
            4'd7: return 8'hE0;
            4'd8: return 8'hFE;
            4'd9: return 8'hF6;
            4'hF: return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int model_idx();
        return 7 - ((k / S) % 8);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        logic [7:0]  e_sel, e_d1, e_d2, seg;
        logic [31:0] d;
        logic [7:0]  m;
        int          idx;
        bit          bon;
        bit          rst_now;
        rst_now = rst;
        e_sel = 8'h00;
        e_d1  = 8'h00;
        e_d2  = 8'h00;
        if (rst_now) begin
            k = 0;
        end else begin
            idx = model_idx();
            bon = ((k / B) % 2) == 0;
            d   = (k == 0) ? time_data : sh_data;
            m   = (k == 0) ? blink_mask : sh_mask;
            seg = ref_seg(d[idx*4 +: 4]);
            if (m[idx] && !bon) seg = 8'h00;
            e_sel = 8'(1 << idx);
            if (idx >= 4) e_d1 = seg;
            else e_d2 = seg;
            // Frame 0 latches at the first edge; later frames at the edge leaving tube 0.
            if (k == 0 || ((k + 1) % (8 * S)) == 0) begin
                sh_data = time_data;
                sh_mask = blink_mask;
            end
            k++;
        end
        @(posedge clk);
        #1;
        check("tube_sel", {24'h0, tube_sel}, {24'h0, e_sel});
        check("digit1", {24'h0, digit1}, {24'h0, e_d1});
        check("digit2", {24'h0, digit2}, {24'h0, e_d2});
        if (!rst_now) begin
            check("onehot", {31'h0, $onehot(tube_sel)}, 32'd1);
            check("exclusive", {31'h0, (digit1 != 8'h00) && (digit2 != 8'h00)}, 32'd0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_idx(input int target);
        for (int i = 0; i < 8 * S + 1 && model_idx() != target; i++) step();
    endtask

    task automatic run_to_frame();
        for (int i = 0; i < 8 * S + 1 && (k % (8 * S)) != 0; i++) step();
    endtask

    initial begin
        // T1: held reset, then a full scan with random data
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        time_data = $urandom;
        run(8 * S + 4);

        // T2: 12-34-56 shown from a frame start
        time_data  = 32'h12F34F56;
        blink_mask = 8'h00;
        run_to_frame();
        run(8 * S);

        // T3: change while tube 5 is lit; current frame must not tear
        run_to_idx(5);
        time_data = 32'h99F99F99;
        run(2 * 8 * S);

        // T4: blinking seconds across several blink phases
        time_data  = 32'h00F00F59;
        blink_mask = 8'h03;
        run(3 * B);

        // T5: blank codes A..E
        time_data  = 32'hABCDE0F0;
        blink_mask = 8'h00;
        run(2 * 8 * S);

        // T6: reset mid-scan, fresh capture on release
        run_to_idx(4);
        step();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        time_data  = 32'h23F59F01;
        blink_mask = 8'hC0;
        run(8 * S + 4);

        // Random: input changes at arbitrary points, occasional resets
        for (int it = 0; it < 80; it++) begin
            time_data  = $urandom;
            blink_mask = 8'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                run(int'($urandom_range(1, 3)));
                rst = 1'b0;
            end
            run(int'($urandom_range(1, 40)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
